// File: rtl/led_display_pkg.sv
// Shared constants, types and helpers for the multiplexed seven-segment display controller.
// Optional build macro: LED_LEADING_ZERO_BLANK_EN (blanks leading zero digits).
package led_display_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low patterns, bit0=a .. bit6=g, bit7=dp (dp never lit)
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic {
        LIVE   = 1'b0,
        FROZEN = 1'b1
    } mode_e;

    function automatic logic [3:0] nibble_of(input logic [31:0] value, input logic [2:0] idx);
        return value[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic upper_is_zero(input logic [31:0] value, input logic [2:0] idx);
        return ((value >> {idx, 2'b00}) == 32'h0000_0000);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decoder
    import led_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] seg_o
);

    assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/led_display_ctrl.sv
// 8-digit time-multiplexed hex display with a debounced live/frozen toggle button.
// Optional build macro: LED_LEADING_ZERO_BLANK_EN (blank digits above the most significant non-zero nibble).
module led_display_ctrl
    import led_display_pkg::*;
#(
    parameter int SCAN_DIV   = 100000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  button,
    input  logic [31:0]           counter,
    output logic [NUM_DIGITS-1:0] led_en,
    output logic [7:0]            led_cx
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

    logic [SCAN_W-1:0]     scan_q, scan_d;
    logic [2:0]            idx_q, idx_d;
    logic                  sync1_q, sync2_q;
    logic [DEB_W-1:0]      deb_cnt_q, deb_cnt_d;
    logic                  deb_q, deb_d;
    mode_e                 mode_q, mode_d;
    logic [31:0]           snap_q, snap_d;
    logic [NUM_DIGITS-1:0] led_en_q, led_en_d;
    logic [7:0]            led_cx_q, led_cx_d;
    logic [31:0]           disp_s;
    logic [3:0]            nibble_s;
    logic [7:0]            seg_s;

    // Scan divider: hold each digit SCAN_DIV cycles, then advance the digit index
    always_comb begin
        scan_d = scan_q + SCAN_W'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = idx_q + 3'd1;
        end else begin
            idx_d  = idx_q;
        end
    end

    // Debounce: accept a new level only after DEB_CYCLES consecutive differing samples
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        deb_d     = deb_q;
        if (sync2_q == deb_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_d     = sync2_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
    end

    // Mode toggle on a debounced press; snapshot taken on entry to FROZEN
    always_comb begin
        mode_d = mode_q;
        snap_d = snap_q;
        if (deb_d && !deb_q) begin
            if (mode_q == LIVE) begin
                mode_d = FROZEN;
                snap_d = counter;
            end else begin
                mode_d = LIVE;
            end
        end else begin
            mode_d = mode_q;
        end
    end

    assign disp_s   = (mode_q == FROZEN) ? snap_q : counter;
    assign nibble_s = nibble_of(disp_s, idx_q);

    seg7_decoder u_seg7_decoder (
        .nibble_i (nibble_s),
        .seg_o    (seg_s)
    );

    // Next output pattern for the digit currently selected by the scan index
    always_comb begin
        led_en_d = ~(NUM_DIGITS'(1) << idx_q);
        led_cx_d = seg_s;
`ifdef LED_LEADING_ZERO_BLANK_EN
        if ((idx_q != 3'd0) && upper_is_zero(disp_s, idx_q)) begin
            led_cx_d = SEG_BLANK;
        end else begin
            led_cx_d = seg_s;
        end
`else
        led_cx_d = seg_s;
`endif
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q    <= '0;
            idx_q     <= 3'd0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_cnt_q <= '0;
            deb_q     <= 1'b0;
            mode_q    <= LIVE;
            snap_q    <= 32'h0000_0000;
            led_en_q  <= {NUM_DIGITS{1'b1}};
            led_cx_q  <= SEG_BLANK;
        end else begin
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            sync1_q   <= button;
            sync2_q   <= sync1_q;
            deb_cnt_q <= deb_cnt_d;
            deb_q     <= deb_d;
            mode_q    <= mode_d;
            snap_q    <= snap_d;
            led_en_q  <= led_en_d;
            led_cx_q  <= led_cx_d;
        end
    end

    assign led_en = led_en_q;
    assign led_cx = led_cx_q;

endmodule

// File: tb/tb_led_display_ctrl.sv
// Randomized self-checking bench for led_display_ctrl against a cycle-count based display model.
`timescale 1ns/1ps
module tb_led_display_ctrl;

    localparam int SCAN_DIV   = 4;
    localparam int DEB_CYCLES = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        button;
    logic [31:0] counter;
    logic [7:0]  led_en;
    logic [7:0]  led_cx;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic        exp_frozen;
    logic [31:0] exp_snap;

    logic [7:0] seg_ref [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    always #5 clk = ~clk;

    led_display_ctrl #(
        .SCAN_DIV   (SCAN_DIV),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .button  (button),
        .counter (counter),
        .led_en  (led_en),
        .led_cx  (led_cx)
    );

    function automatic logic [7:0] ref_cx(input logic [31:0] v, input int k);
        logic [31:0] upper;
        upper = v >> (4 * k);
`ifdef LED_LEADING_ZERO_BLANK_EN
        if (k != 0 && upper == 32'd0) return 8'hFF;
`endif
        return seg_ref[upper[3:0]];
    endfunction

    // One clock; output after the n-th edge since reset shows digit ((n-1)/SCAN_DIV) mod 8
    task automatic cycle_check(input string nm);
        logic [31:0] disp;
        logic [7:0]  e_en;
        logic [7:0]  e_cx;
        int          k;
        disp = exp_frozen ? exp_snap : counter;
        @(negedge clk);
        cyc++;
        k    = ((cyc - 1) / SCAN_DIV) % 8;
        e_en = ~(8'h01 << k);
        e_cx = ref_cx(disp, k);
        vectors++;
        if (led_en !== e_en) begin
            miscompares++;
            $display("FAIL %s led_en got %h want %h (cycle %0d)", nm, led_en, e_en, cyc);
        end
        vectors++;
        if (led_cx !== e_cx) begin
            miscompares++;
            $display("FAIL %s led_cx got %h want %h (cycle %0d, digit %0d, value %h)", nm, led_cx, e_cx, cyc, k, disp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic press(input int len);
        button = 1'b1;
        tick(len);
        button = 1'b0;
        tick(12);
        if (len >= DEB_CYCLES) begin
            if (!exp_frozen) exp_snap = counter;
            exp_frozen = ~exp_frozen;
        end
    endtask

    task automatic run_random(input string nm, input int n);
        repeat (n) begin
            counter = $urandom;
            if ($urandom_range(0, 2) == 0) counter = counter >> (4 * $urandom_range(1, 7));
            cycle_check(nm);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        button     = 1'b0;
        counter    = 32'h1234_5678;
        exp_frozen = 1'b0;
        exp_snap   = 32'h0;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (led_en !== 8'hFF || led_cx !== 8'hFF) begin
                miscompares++;
                $display("FAIL reset_hold en/cx got %h/%h want FF/FF", led_en, led_cx);
            end
        end
        rst = 1'b0;
        cyc = 0;
        repeat (8) cycle_check("reset_release");
    endtask

    task automatic test_full_scan();
        counter = 32'h89AB_CDEF;
        repeat (36) cycle_check("full_scan");
        run_random("live_random", 48);
    endtask

    task automatic test_freeze();
        counter = 32'h0000_0005;
        press(10);
        counter = 32'h0000_0009;
        repeat (36) cycle_check("freeze_hold");
        press(10);
        repeat (8) cycle_check("unfreeze");
    endtask

    task automatic test_debounce();
        counter = $urandom;
        press(2);
        run_random("short_pulse", 12);
        counter = $urandom;
        press($urandom_range(1, 2));
        run_random("short_rand", 12);
        counter = $urandom;
        press(DEB_CYCLES);
        run_random("min_pulse", 34);
        counter = $urandom;
        press(6);
        run_random("pulse6", 12);
        counter = $urandom;
        press(100);
        run_random("hold100", 34);
        counter = $urandom;
        press(1);
        run_random("glitch", 12);
    endtask

    task automatic test_async_reset();
        if (!exp_frozen) press(8);
        counter = $urandom;
        @(negedge clk);
        cyc++;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (led_en !== 8'hFF || led_cx !== 8'hFF) begin
            miscompares++;
            $display("FAIL async_reset en/cx got %h/%h want FF/FF", led_en, led_cx);
        end
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b0;
        cyc        = 0;
        exp_frozen = 1'b0;
        exp_snap   = 32'h0;
        run_random("after_reset", 36);
    endtask

    task automatic test_blank_values();
        if (exp_frozen) press(8);
        counter = 32'h0000_00A0;
        repeat (36) cycle_check("value_A0");
        counter = 32'h0000_0000;
        repeat (36) cycle_check("value_0");
    endtask

    initial begin
        rst     = 1'b1;
        button  = 1'b0;
        counter = 32'h0;
        test_reset();
        test_full_scan();
        test_freeze();
        test_debounce();
        test_async_reset();
        test_blank_values();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
